// File: rtl/plab5_mcore_net_resp_unpacker.sv
// Core-side receive stage for memory responses arriving over the response
// network. It strips the network header and drops messages addressed to
// another core. Fail and domain-violation responses are flagged and have
// their data zeroed. Accepted responses are buffered in a 2-entry FIFO that
// feeds the core over val/rdy. Saturating counters track misrouted and
// domain-violating messages.
module plab5_mcore_net_resp_unpacker #(
  parameter int p_core_id           = 0,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  localparam int c_rc = 3 + p_mem_opaque_nbits + 2,
  localparam int c_nc = 2 * p_net_srcdest_nbits + p_net_opaque_nbits + 2 + c_rc,
  localparam int c_om = c_rc + p_mem_data_nbits
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        core_domain,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [c_nc-1:0]             in_msg_control,
  input  logic [p_mem_data_nbits-1:0] in_msg_data,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [c_om-1:0]             out_msg,
  output logic                        out_fail,
  output logic                        out_viol,
  output logic [7:0]                  misroute_cnt,
  output logic [7:0]                  viol_cnt
);

  localparam int c_ns = p_net_srcdest_nbits;
  localparam logic [c_ns-1:0] c_core_id = c_ns'(p_core_id);

  // Header fields of the incoming network message
  logic [c_ns-1:0] dest;
  logic            msg_domain;
  logic            msg_fail;
  logic [c_rc-1:0] resp_control;

  assign dest         = in_msg_control[c_nc-1 -: c_ns];
  assign msg_domain   = in_msg_control[c_rc+1];
  assign msg_fail     = in_msg_control[c_rc];
  assign resp_control = in_msg_control[c_rc-1:0];

  // Source id and network opaque are not needed once the message has arrived
  logic unused_hdr;
  assign unused_hdr = ^in_msg_control[c_nc-c_ns-1 : c_rc+2];

  // FIFO state
  logic       enq_ptr;
  logic       deq_ptr;
  logic [1:0] count;

  logic [c_om-1:0] entry_msg  [2];
  logic            entry_fail [2];
  logic            entry_viol [2];

  // Handshake and classification of the current cycle
  logic accept;
  logic dest_ok;
  logic enq;
  logic misroute;
  logic viol;
  logic deq;

  assign in_rdy   = (count != 2'd2);
  assign out_val  = (count != 2'd0);
  assign accept   = in_val & in_rdy;
  assign dest_ok  = (dest == c_core_id);
  assign enq      = accept & dest_ok;
  assign misroute = accept & ~dest_ok;
  assign viol     = (msg_domain != core_domain);
  assign deq      = out_val & out_rdy;

  // Build the entry to enqueue; data is suppressed on fail or violation
  logic [c_om-1:0] enq_msg;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    enq_msg = {resp_control, in_msg_data};
    if (viol || msg_fail) begin
      enq_msg = {resp_control, {p_mem_data_nbits{1'b0}}};
    end
  end

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      enq_ptr <= 1'b0;
      deq_ptr <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (enq) enq_ptr <= ~enq_ptr;
      if (deq) deq_ptr <= ~deq_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage written at the enqueue slot
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count = 0 already marks every entry invalid and outputs are masked.
    if (enq) begin
      entry_msg[enq_ptr]  <= enq_msg;
      entry_fail[enq_ptr] <= msg_fail;
      entry_viol[enq_ptr] <= viol;
    end
  end

  // Saturating event counters, updated at the accept edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      misroute_cnt <= 8'd0;
      viol_cnt     <= 8'd0;
    end else begin
      if (misroute && misroute_cnt != 8'hFF) misroute_cnt <= misroute_cnt + 8'd1;
      if (enq && viol && viol_cnt != 8'hFF)  viol_cnt     <= viol_cnt + 8'd1;
    end
  end

  // Head-of-queue outputs, forced to zero when empty
  assign out_msg  = out_val ? entry_msg[deq_ptr]  : '0;
  assign out_fail = out_val ? entry_fail[deq_ptr] : 1'b0;
  assign out_viol = out_val ? entry_viol[deq_ptr] : 1'b0;

endmodule

// File: tb/tb_plab5_mcore_net_resp_unpacker.sv
// Directed bench for plab5_mcore_net_resp_unpacker at default parameters
// (core id 0, 25-bit control, 45-bit output message).
module tb_plab5_mcore_net_resp_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_domain;
  logic        in_val;
  logic        in_rdy;
  logic [24:0] in_msg_control;
  logic [31:0] in_msg_data;
  logic        out_val;
  logic        out_rdy;
  logic [44:0] out_msg;
  logic        out_fail;
  logic        out_viol;
  logic [7:0]  misroute_cnt;
  logic [7:0]  viol_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  plab5_mcore_net_resp_unpacker dut (
    .clk            (clk),
    .reset          (reset),
    .core_domain    (core_domain),
    .in_val         (in_val),
    .in_rdy         (in_rdy),
    .in_msg_control (in_msg_control),
    .in_msg_data    (in_msg_data),
    .out_val        (out_val),
    .out_rdy        (out_rdy),
    .out_msg        (out_msg),
    .out_fail       (out_fail),
    .out_viol       (out_viol),
    .misroute_cnt   (misroute_cnt),
    .viol_cnt       (viol_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        dom;
    logic        iv;
    logic [24:0] ctrl;
    logic [31:0] data;
    logic        ordy;
    logic        e_rdy;
    logic        e_val;
    logic [44:0] e_msg;
    logic        e_fail;
    logic        e_viol;
    logic [7:0]  e_mc;
    logic [7:0]  e_vc;
  } vec_t;

  // Network control word: nonzero src and net opaque to exercise stripping
  function automatic logic [24:0] mk_ctrl(input logic [2:0] dest, input logic dom,
                                          input logic fl, input logic [2:0] typ,
                                          input logic [7:0] opq, input logic [1:0] len);
    return {dest, 3'd5, 4'hA, dom, fl, typ, opq, len};
  endfunction

  function automatic logic [44:0] mk_out(input logic [2:0] typ, input logic [7:0] opq,
                                         input logic [1:0] len, input logic [31:0] data);
    return {typ, opq, len, data};
  endfunction

  function automatic vec_t mkv(input logic rst, dom, iv, input logic [24:0] ctrl,
                               input logic [31:0] data, input logic ordy,
                               input logic e_rdy, e_val, input logic [44:0] e_msg,
                               input logic e_fail, e_viol, input logic [7:0] e_mc, e_vc);
    vec_t v;
    v.rst = rst; v.dom = dom; v.iv = iv; v.ctrl = ctrl; v.data = data; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_msg = e_msg;
    v.e_fail = e_fail; v.e_viol = e_viol; v.e_mc = e_mc; v.e_vc = e_vc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_rdy, e_val,
                           input logic [44:0] e_msg, input logic e_fail, e_viol,
                           input logic [7:0] e_mc, e_vc);
    check({tag, ".in_rdy"},       64'(in_rdy),       64'(e_rdy));
    check({tag, ".out_val"},      64'(out_val),      64'(e_val));
    check({tag, ".out_msg"},      64'(out_msg),      64'(e_msg));
    check({tag, ".out_fail"},     64'(out_fail),     64'(e_fail));
    check({tag, ".out_viol"},     64'(out_viol),     64'(e_viol));
    check({tag, ".misroute_cnt"}, 64'(misroute_cnt), 64'(e_mc));
    check({tag, ".viol_cnt"},     64'(viol_cnt),     64'(e_vc));
  endtask

  // Drive inputs on the falling edge, then let one rising edge pass and settle
  task automatic step(input logic rst, dom, iv, input logic [24:0] ctrl,
                      input logic [31:0] data, input logic ordy);
    @(negedge clk);
    reset = rst; core_domain = dom; in_val = iv;
    in_msg_control = ctrl; in_msg_data = data; out_rdy = ordy;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[14];
  logic [24:0] c_mis;
  logic [24:0] c_a, c_b, c_c;

  initial begin
    reset = 1'b0; core_domain = 1'b0; in_val = 1'b0;
    in_msg_control = '0; in_msg_data = '0; out_rdy = 1'b0;

    // rst dom iv ctrl data ordy | rdy val msg fail viol mc vc
    vecs[0]  = mkv(0, 0, 0, '0, '0, 1,  1, 0, '0, 0, 0, 8'd0, 8'd0);
    vecs[1]  = mkv(0, 0, 0, '0, '0, 1,  1, 0, '0, 0, 0, 8'd0, 8'd0);
    vecs[2]  = mkv(1, 0, 0, '0, '0, 1,  1, 0, '0, 0, 0, 8'd0, 8'd0);
    vecs[3]  = mkv(1, 0, 1, mk_ctrl(3'd0, 0, 0, 3'd0, 8'h05, 2'd0), 32'hDEADBEEF, 1,
                   1, 1, mk_out(3'd0, 8'h05, 2'd0, 32'hDEADBEEF), 0, 0, 8'd0, 8'd0);
    vecs[4]  = mkv(1, 0, 0, '0, '0, 1,  1, 0, '0, 0, 0, 8'd0, 8'd0);
    vecs[5]  = mkv(1, 0, 1, mk_ctrl(3'd1, 0, 0, 3'd0, 8'h07, 2'd0), 32'h11111111, 1,
                   1, 0, '0, 0, 0, 8'd1, 8'd0);
    vecs[6]  = mkv(1, 0, 1, mk_ctrl(3'd0, 1, 0, 3'd1, 8'h22, 2'd1), 32'h12345678, 1,
                   1, 1, mk_out(3'd1, 8'h22, 2'd1, 32'h0), 0, 1, 8'd1, 8'd1);
    vecs[7]  = mkv(1, 0, 0, '0, '0, 1,  1, 0, '0, 0, 0, 8'd1, 8'd1);
    vecs[8]  = mkv(1, 0, 1, mk_ctrl(3'd0, 0, 1, 3'd2, 8'h33, 2'd2), 32'hAAAA5555, 1,
                   1, 1, mk_out(3'd2, 8'h33, 2'd2, 32'h0), 1, 0, 8'd1, 8'd1);
    vecs[9]  = mkv(1, 0, 0, '0, '0, 1,  1, 0, '0, 0, 0, 8'd1, 8'd1);
    vecs[10] = mkv(1, 0, 1, mk_ctrl(3'd0, 1, 1, 3'd4, 8'h3C, 2'd3), 32'hCAFEF00D, 1,
                   1, 1, mk_out(3'd4, 8'h3C, 2'd3, 32'h0), 1, 1, 8'd1, 8'd2);
    vecs[11] = mkv(1, 0, 0, '0, '0, 1,  1, 0, '0, 0, 0, 8'd1, 8'd2);
    vecs[12] = mkv(1, 1, 1, mk_ctrl(3'd0, 1, 0, 3'd3, 8'h44, 2'd3), 32'h0BADF00D, 1,
                   1, 1, mk_out(3'd3, 8'h44, 2'd3, 32'h0BADF00D), 0, 0, 8'd1, 8'd2);
    vecs[13] = mkv(1, 1, 0, '0, '0, 1,  1, 0, '0, 0, 0, 8'd1, 8'd2);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].dom, vecs[i].iv, vecs[i].ctrl, vecs[i].data, vecs[i].ordy);
      check_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_val, vecs[i].e_msg,
                vecs[i].e_fail, vecs[i].e_viol, vecs[i].e_mc, vecs[i].e_vc);
    end

    // Misroute saturation: 300 more misrouted messages on top of the one above
    c_mis = mk_ctrl(3'd6, 0, 0, 3'd0, 8'h01, 2'd0);
    for (int i = 0; i < 253; i++) step(1, 0, 1, c_mis, 32'h5, 1);
    check_all("mis254", 1, 0, '0, 0, 0, 8'd254, 8'd2);
    for (int i = 0; i < 47; i++) step(1, 0, 1, c_mis, 32'h5, 1);
    check_all("mis255", 1, 0, '0, 0, 0, 8'd255, 8'd2);

    // Backpressure: A, B fill the FIFO, C waits until the consumer drains
    c_a = mk_ctrl(3'd0, 0, 0, 3'd1, 8'h10, 2'd0);
    c_b = mk_ctrl(3'd0, 0, 0, 3'd1, 8'h11, 2'd0);
    c_c = mk_ctrl(3'd0, 0, 0, 3'd1, 8'h12, 2'd0);
    step(1, 0, 1, c_a, 32'hA, 0);
    check_all("bp_a", 1, 1, mk_out(3'd1, 8'h10, 2'd0, 32'hA), 0, 0, 8'd255, 8'd2);
    step(1, 0, 1, c_b, 32'hB, 0);
    check_all("bp_full", 0, 1, mk_out(3'd1, 8'h10, 2'd0, 32'hA), 0, 0, 8'd255, 8'd2);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1, c_c, 32'hC, 0);
      check_all($sformatf("bp_stall%0d", i), 0, 1, mk_out(3'd1, 8'h10, 2'd0, 32'hA),
                0, 0, 8'd255, 8'd2);
    end
    step(1, 0, 1, c_c, 32'hC, 1);
    check_all("bp_deq_a", 1, 1, mk_out(3'd1, 8'h11, 2'd0, 32'hB), 0, 0, 8'd255, 8'd2);
    step(1, 0, 1, c_c, 32'hC, 1);
    check_all("bp_deq_b", 1, 1, mk_out(3'd1, 8'h12, 2'd0, 32'hC), 0, 0, 8'd255, 8'd2);
    step(1, 0, 0, '0, '0, 1);
    check_all("bp_deq_c", 1, 0, '0, 0, 0, 8'd255, 8'd2);

    // Simultaneous enqueue/dequeue at count = 1, pointers wrap every cycle
    step(1, 0, 1, mk_ctrl(3'd0, 0, 0, 3'd0, 8'd0, 2'd1), 32'h1000, 1);
    check_all("sim0", 1, 1, mk_out(3'd0, 8'd0, 2'd1, 32'h1000), 0, 0, 8'd255, 8'd2);
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 1, mk_ctrl(3'd0, 0, 0, 3'd0, 8'(i), 2'd1), 32'h1000 + 32'(i), 1);
      check_all($sformatf("sim%0d", i), 1, 1, mk_out(3'd0, 8'(i), 2'd1, 32'h1000 + 32'(i)),
                0, 0, 8'd255, 8'd2);
    end

    // Reset mid-stream flushes the FIFO and clears counters
    step(0, 0, 1, mk_ctrl(3'd0, 0, 0, 3'd0, 8'd11, 2'd1), 32'h100B, 1);
    check_all("rst_mid", 1, 0, '0, 0, 0, 8'd0, 8'd0);
    step(1, 0, 0, '0, '0, 1);
    check_all("rst_idle", 1, 0, '0, 0, 0, 8'd0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
